// File: rtl/shot_game_ctrl_if.sv
// Signal bundle between the shot-game controller and its surroundings:
// the tick, button and shot-clock inputs plus the score/state outputs.
interface shot_game_ctrl_if;
    logic       tick_1hz;
    logic       shoot;
    logic       make;
    logic       clock_zero;
    logic       clock_load;
    logic [7:0] score_bcd;
    logic [7:0] attempts_bcd;
    logic [2:0] state;
    logic       violation;
    logic       made;

    modport master (
        output tick_1hz, shoot, make, clock_zero,
        input  clock_load, score_bcd, attempts_bcd, state, violation, made
    );

    modport slave (
        input  tick_1hz, shoot, make, clock_zero,
        output clock_load, score_bcd, attempts_bcd, state, violation, made
    );
endinterface

// File: rtl/shot_game_ctrl.sv
// Shot-game controller: sequences shot clock, release, make window and hold,
// keeping saturating two-digit BCD score and attempt counters.
module shot_game_ctrl #(
    parameter int unsigned POINTS_PER_MAKE = 2,
    parameter int unsigned FLIGHT_TICKS    = 3,
    parameter int unsigned HOLD_TICKS      = 2
) (
    input  logic            CLK100MHZ,
    input  logic            rst_n,
    shot_game_ctrl_if.slave gif
);
    localparam int unsigned     MAX_TICKS   = (FLIGHT_TICKS > HOLD_TICKS) ? FLIGHT_TICKS : HOLD_TICKS;
    localparam int unsigned     CNT_W       = $clog2(MAX_TICKS + 1);
    localparam logic [CNT_W-1:0] FLIGHT_LAST = CNT_W'(FLIGHT_TICKS - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_TICKS - 1);
    localparam logic [1:0]       POINTS      = 2'(POINTS_PER_MAKE);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RUN    = 3'd2,
        FLIGHT = 3'd3,
        RESULT = 3'd4,
        VIOL   = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       score_q, score_d;
    logic [7:0]       attempts_q, attempts_d;
    logic             clock_load_q, clock_load_d;
    logic             made_q, made_d;
    logic             violation_q, violation_d;

    // Add via binary so the result is always two valid digits, clamped at 99.
    function automatic logic [7:0] bcd_add_sat(input logic [7:0] bcd, input logic [1:0] inc);
        logic [6:0] bin;
        bin = 7'(bcd[7:4]) * 7'd10 + 7'(bcd[3:0]) + 7'(inc);
        if (bin > 7'd99) bin = 7'd99;
        return {4'(bin / 7'd10), 4'(bin % 7'd10)};
    endfunction

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        cnt_d        = cnt_q;
        score_d      = score_q;
        attempts_d   = attempts_q;
        clock_load_d = 1'b0;
        made_d       = made_q;

        case (state_q)
            IDLE: begin
                if (gif.shoot) begin
                    state_d      = LOAD;
                    clock_load_d = 1'b1;
                end
            end
            LOAD: begin
                if (!gif.clock_zero) state_d = RUN;
            end
            RUN: begin
                // The buzzer beats a simultaneous release.
                if (gif.clock_zero) begin
                    state_d = VIOL;
                end else if (gif.shoot) begin
                    attempts_d = bcd_add_sat(attempts_q, 2'd1);
                    state_d    = FLIGHT;
                end
            end
            FLIGHT: begin
                if (gif.make) begin
                    score_d = bcd_add_sat(score_q, POINTS);
                    made_d  = 1'b1;
                    state_d = RESULT;
                end else if (gif.tick_1hz) begin
                    if (cnt_q == FLIGHT_LAST) begin
                        made_d  = 1'b0;
                        state_d = RESULT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            RESULT, VIOL: begin
                if (gif.tick_1hz) begin
                    if (cnt_q == HOLD_LAST) state_d = IDLE;
                    else                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) cnt_d  = '0;
        if (state_d != RESULT)  made_d = 1'b0;
        violation_d = (state_d == VIOL);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK100MHZ) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            score_q      <= 8'h00;
            attempts_q   <= 8'h00;
            clock_load_q <= 1'b0;
            made_q       <= 1'b0;
            violation_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            score_q      <= score_d;
            attempts_q   <= attempts_d;
            clock_load_q <= clock_load_d;
            made_q       <= made_d;
            violation_q  <= violation_d;
        end
    end

    assign gif.state        = state_q;
    assign gif.score_bcd    = score_q;
    assign gif.attempts_bcd = attempts_q;
    assign gif.clock_load   = clock_load_q;
    assign gif.made         = made_q;
    assign gif.violation    = violation_q;
endmodule

// File: tb/tb_shot_game_ctrl.sv
// Directed bench for shot_game_ctrl: a vector table for the basic flows plus
// hand sequences for BCD carry/saturation and reset during flight.
module tb_shot_game_ctrl;
    logic CLK100MHZ;
    logic rst_n;

    shot_game_ctrl_if gif ();
    shot_game_ctrl_if gif3 ();

    shot_game_ctrl #(.POINTS_PER_MAKE(2), .FLIGHT_TICKS(3), .HOLD_TICKS(2)) dut (
        .CLK100MHZ (CLK100MHZ),
        .rst_n     (rst_n),
        .gif       (gif.slave)
    );

    // Second instance sees identical stimulus; only its score step differs.
    shot_game_ctrl #(.POINTS_PER_MAKE(3), .FLIGHT_TICKS(3), .HOLD_TICKS(2)) dut3 (
        .CLK100MHZ (CLK100MHZ),
        .rst_n     (rst_n),
        .gif       (gif3.slave)
    );

    assign gif3.tick_1hz   = gif.tick_1hz;
    assign gif3.shoot      = gif.shoot;
    assign gif3.make       = gif.make;
    assign gif3.clock_zero = gif.clock_zero;

    initial begin
        CLK100MHZ = 1'b0;
        forever #5 CLK100MHZ = ~CLK100MHZ;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst_n, shoot, make, tick, cz;
        logic [2:0] st;
        logic       cl;
        logic [7:0] sc, at;
        logic       md, vi;
    } vec_t;

    function automatic vec_t v(input logic r, sh, mk, tk, cz, input logic [2:0] st,
                               input logic cl, input logic [7:0] sc, at, input logic md, vi);
        vec_t x;
        x = '{r, sh, mk, tk, cz, st, cl, sc, at, md, vi};
        return x;
    endfunction

    function automatic logic [7:0] to_bcd(input int n);
        int m;
        m = (n > 99) ? 99 : n;
        return {4'(m / 10), 4'(m % 10)};
    endfunction

    // One clock with the given inputs; outputs are stable when this returns.
    task automatic drive(input logic sh, mk, tk, cz);
        gif.shoot = sh; gif.make = mk; gif.tick_1hz = tk; gif.clock_zero = cz;
        @(posedge CLK100MHZ);
        #1;
        gif.shoot = 1'b0; gif.make = 1'b0; gif.tick_1hz = 1'b0;
    endtask

    task automatic play_game(input logic do_make);
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        if (do_make) drive(0, 1, 0, 0);
        else for (int t = 0; t < 3; t++) drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);
    endtask

    vec_t vecs[$];

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        gif.shoot = 1'b0; gif.make = 1'b0; gif.tick_1hz = 1'b0; gif.clock_zero = 1'b1;

        //                 rst sh mk tk cz   st   cl  score  att   md vi
        vecs.push_back(v(0, 0, 0, 0, 1, 3'd0, 0, 8'h00, 8'h00, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 3'd0, 0, 8'h00, 8'h00, 0, 0));
        vecs.push_back(v(1, 1, 0, 0, 1, 3'd1, 1, 8'h00, 8'h00, 0, 0));
        vecs.push_back(v(1, 0, 1, 0, 1, 3'd1, 0, 8'h00, 8'h00, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 3'd2, 0, 8'h00, 8'h00, 0, 0));
        vecs.push_back(v(1, 0, 0, 1, 0, 3'd2, 0, 8'h00, 8'h00, 0, 0));
        vecs.push_back(v(1, 1, 0, 0, 0, 3'd3, 0, 8'h00, 8'h01, 0, 0));
        vecs.push_back(v(1, 0, 0, 1, 1, 3'd3, 0, 8'h00, 8'h01, 0, 0));
        vecs.push_back(v(1, 0, 1, 0, 0, 3'd4, 0, 8'h02, 8'h01, 1, 0));
        vecs.push_back(v(1, 1, 1, 0, 0, 3'd4, 0, 8'h02, 8'h01, 1, 0));
        vecs.push_back(v(1, 0, 0, 1, 0, 3'd4, 0, 8'h02, 8'h01, 1, 0));
        vecs.push_back(v(1, 0, 0, 1, 0, 3'd0, 0, 8'h02, 8'h01, 0, 0));
        // flight timeout, no make
        vecs.push_back(v(1, 1, 0, 0, 0, 3'd1, 1, 8'h02, 8'h01, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 3'd2, 0, 8'h02, 8'h01, 0, 0));
        vecs.push_back(v(1, 1, 0, 0, 0, 3'd3, 0, 8'h02, 8'h02, 0, 0));
        vecs.push_back(v(1, 0, 0, 1, 0, 3'd3, 0, 8'h02, 8'h02, 0, 0));
        vecs.push_back(v(1, 0, 0, 1, 0, 3'd3, 0, 8'h02, 8'h02, 0, 0));
        vecs.push_back(v(1, 0, 0, 1, 0, 3'd4, 0, 8'h02, 8'h02, 0, 0));
        vecs.push_back(v(1, 0, 0, 1, 0, 3'd4, 0, 8'h02, 8'h02, 0, 0));
        vecs.push_back(v(1, 0, 1, 0, 0, 3'd4, 0, 8'h02, 8'h02, 0, 0));
        vecs.push_back(v(1, 0, 0, 1, 0, 3'd0, 0, 8'h02, 8'h02, 0, 0));
        // buzzer and shoot together
        vecs.push_back(v(1, 1, 0, 0, 0, 3'd1, 1, 8'h02, 8'h02, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 3'd2, 0, 8'h02, 8'h02, 0, 0));
        vecs.push_back(v(1, 1, 0, 0, 1, 3'd5, 0, 8'h02, 8'h02, 0, 1));
        vecs.push_back(v(1, 0, 0, 1, 1, 3'd5, 0, 8'h02, 8'h02, 0, 1));
        vecs.push_back(v(1, 0, 0, 1, 1, 3'd0, 0, 8'h02, 8'h02, 0, 0));
        vecs.push_back(v(1, 0, 1, 0, 0, 3'd0, 0, 8'h02, 8'h02, 0, 0));
        // make together with the expiring tick; shoot/make ignored in LOAD
        vecs.push_back(v(1, 1, 0, 0, 0, 3'd1, 1, 8'h02, 8'h02, 0, 0));
        vecs.push_back(v(1, 1, 1, 0, 0, 3'd2, 0, 8'h02, 8'h02, 0, 0));
        vecs.push_back(v(1, 1, 0, 0, 0, 3'd3, 0, 8'h02, 8'h03, 0, 0));
        vecs.push_back(v(1, 0, 0, 1, 0, 3'd3, 0, 8'h02, 8'h03, 0, 0));
        vecs.push_back(v(1, 0, 0, 1, 0, 3'd3, 0, 8'h02, 8'h03, 0, 0));
        vecs.push_back(v(1, 0, 1, 1, 0, 3'd4, 0, 8'h04, 8'h03, 1, 0));
        vecs.push_back(v(1, 0, 0, 1, 0, 3'd4, 0, 8'h04, 8'h03, 1, 0));
        vecs.push_back(v(1, 0, 0, 1, 0, 3'd0, 0, 8'h04, 8'h03, 0, 0));
        // buzzer alone in RUN
        vecs.push_back(v(1, 1, 0, 0, 0, 3'd1, 1, 8'h04, 8'h03, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 3'd2, 0, 8'h04, 8'h03, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 3'd5, 0, 8'h04, 8'h03, 0, 1));
        vecs.push_back(v(1, 0, 0, 1, 1, 3'd5, 0, 8'h04, 8'h03, 0, 1));
        vecs.push_back(v(1, 0, 0, 1, 0, 3'd0, 0, 8'h04, 8'h03, 0, 0));

        repeat (2) @(posedge CLK100MHZ);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n = vecs[i].rst_n;
            drive(vecs[i].shoot, vecs[i].make, vecs[i].tick, vecs[i].cz);
            check($sformatf("row%0d state", i),      8'(gif.state),      8'(vecs[i].st));
            check($sformatf("row%0d clock_load", i), 8'(gif.clock_load), 8'(vecs[i].cl));
            check($sformatf("row%0d score", i),      gif.score_bcd,      vecs[i].sc);
            check($sformatf("row%0d attempts", i),   gif.attempts_bcd,   vecs[i].at);
            check($sformatf("row%0d made", i),       8'(gif.made),       8'(vecs[i].md));
            check($sformatf("row%0d violation", i),  8'(gif.violation),  8'(vecs[i].vi));
        end

        // BCD carry and saturation across a long run of made shots
        rst_n = 1'b0;
        drive(0, 0, 0, 1);
        rst_n = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            play_game(1'b1);
            check($sformatf("game%0d score2", k),   gif.score_bcd,     to_bcd(2 * k));
            check($sformatf("game%0d score3", k),   gif3.score_bcd,    to_bcd(3 * k));
            check($sformatf("game%0d attempts", k), gif.attempts_bcd,  to_bcd(k));
            check($sformatf("game%0d state", k),    8'(gif.state),     8'd0);
        end

        // reset in the middle of FLIGHT, with make/tick colliding on the reset edge
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        check("pre_reset state", 8'(gif.state), 8'd3);
        rst_n = 1'b0;
        drive(0, 1, 1, 0);
        check("rst state",      8'(gif.state),      8'd0);
        check("rst score",      gif.score_bcd,      8'h00);
        check("rst score3",     gif3.score_bcd,     8'h00);
        check("rst attempts",   gif.attempts_bcd,   8'h00);
        check("rst made",       8'(gif.made),       8'd0);
        check("rst violation",  8'(gif.violation),  8'd0);
        check("rst clock_load", 8'(gif.clock_load), 8'd0);
        rst_n = 1'b1;
        drive(0, 1, 0, 0);
        check("late make score", gif.score_bcd, 8'h00);
        check("late make state", 8'(gif.state), 8'd0);
        drive(1, 0, 0, 0);
        check("post_reset state",      8'(gif.state),      8'd1);
        check("post_reset clock_load", 8'(gif.clock_load), 8'd1);
        drive(0, 0, 0, 0);
        check("post_reset load pulse", 8'(gif.clock_load), 8'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
